gxor_arb_par: RTL and testbench

Shared-XOR parity engine with a two-requester round-robin arbiter. Two clients request the block, and it grants one of them. The granted word is reduced serially to a single parity bit through one `gxor` instance, one bit per clock. This is the sequential controller that time-shares the combinational XOR gate among several users.

---
 rtl/gxor_arb_par_if.sv | 17 +
 rtl/gxor_arb_par.sv | 107 ++++++++++
 tb/tb_gxor_arb_par.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/gxor_arb_par_if.sv
// Client-side bus of the shared-XOR parity engine: two request/data pairs in,
// grants and the sticky result out.
interface gxor_arb_par_if #(parameter int W = 8);
  logic         req0, req1;
  logic [W-1:0] data0, data1;
  logic         gnt0, gnt1;
  logic         busy, done, done_id, parity;

  modport slave (
    input  req0, req1, data0, data1,
    output gnt0, gnt1, busy, done, done_id, parity
  );
  modport master (
    output req0, req1, data0, data1,
    input  gnt0, gnt1, busy, done, done_id, parity
  );
endinterface

// File: rtl/gxor_arb_par.sv
// Two-client round-robin arbiter time-sharing one gxor gate to reduce a word to
// parity, LSB first, one bit per clock. GXOR_ARB_ODD_EN selects odd parity.
module gxor (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a ^ b;
endmodule

module gxor_arb_par #(parameter int W = 8) (
  input  logic           clk,
  input  logic           rst,
  gxor_arb_par_if.slave  bus
);
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  shreg_q, shreg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          acc_q, acc_d;
  logic          last_q, last_d;
  logic          gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic          done_q, done_d, done_id_q, done_id_d, parity_q, parity_d;
  logic          y, win;

  gxor u_gxor (.a(acc_q), .b(shreg_q[0]), .y(y));

  // Tie goes to whoever was not served last; otherwise the lone requester wins.
  assign win = (bus.req0 && bus.req1) ? ~last_q : bus.req1;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    last_d    = last_q;
    gnt0_d    = 1'b0;
    gnt1_d    = 1'b0;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    parity_d  = parity_q;
    case (state_q)
      IDLE: if (bus.req0 || bus.req1) begin
        shreg_d = win ? bus.data1 : bus.data0;
        acc_d   = 1'b0;
        cnt_d   = '0;
        last_d  = win;
        gnt0_d  = ~win;
        gnt1_d  = win;
        state_d = RUN;
      end
      RUN: begin
        acc_d   = y;
        shreg_d = shreg_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(W-1)) begin
`ifdef GXOR_ARB_ODD_EN
          parity_d = ~y;
`else
          parity_d = y;
`endif
          done_d    = 1'b1;
          done_id_d = last_q;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      cnt_q     <= '0;
      acc_q     <= 1'b0;
      last_q    <= 1'b1;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      parity_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      last_q    <= last_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      parity_q  <= parity_d;
    end
  end

  assign bus.gnt0    = gnt0_q;
  assign bus.gnt1    = gnt1_q;
  assign bus.busy    = (state_q == RUN) || (state_q == DONE);
  assign bus.done    = done_q;
  assign bus.done_id = done_id_q;
  assign bus.parity  = parity_q;
endmodule

// File: tb/tb_gxor_arb_par.sv
// Bench for gxor_arb_par: directed vectors feed an expected-result queue that a
// negedge monitor drains on every done pulse.
module tb_gxor_arb_par;
  localparam int W = 8;
`ifdef GXOR_ARB_ODD_EN
  localparam logic ODD = 1'b1;
`else
  localparam logic ODD = 1'b0;
`endif

  typedef struct packed { logic id; logic par; } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sb[$];

  gxor_arb_par_if #(.W(W)) bus ();
  gxor_arb_par #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.done) begin
      exp_t e;
      if (sb.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no pending result at %0t", $time);
      end else begin
        e = sb.pop_front();
        chk("done_id", bus.done_id, e.id);
        chk("parity", bus.parity, e.par);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Raise one request, expect its grant on the next edge and done exactly W edges later.
  task automatic serve(input logic id, input logic [W-1:0] d, input logic par);
    if (id) begin bus.req1 = 1'b1; bus.data1 = d; end
    else    begin bus.req0 = 1'b1; bus.data0 = d; end
    sb.push_back('{id: id, par: par ^ ODD});
    tick();
    chk("gnt0", bus.gnt0, ~id);
    chk("gnt1", bus.gnt1, id);
    chk("busy_after_e0", bus.busy, 1'b1);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.data0 = ~d; bus.data1 = ~d;   // data is captured; later changes must not matter
    for (int k = 1; k <= W + 1; k++) begin
      tick();
      chk("done_timing", bus.done, k == W);
      if (k <= W) chk("gnt_clear", bus.gnt0 | bus.gnt1, 1'b0);
    end
    chk("busy_drop", bus.busy, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.req0 = 1'($urandom_range(0, 1));
      bus.req1 = 1'($urandom_range(0, 1));
      bus.data0 = 8'($urandom); bus.data1 = 8'($urandom);
      tick();
      chk("rst_gnt0", bus.gnt0, 1'b0);
      chk("rst_gnt1", bus.gnt1, 1'b0);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_done", bus.done, 1'b0);
      chk("rst_done_id", bus.done_id, 1'b0);
      chk("rst_parity", bus.parity, 1'b0);
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    int n;
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.data0 = '0; bus.data1 = '0;
    do_reset();
    tick();

    serve(1'b0, 8'hA5, 1'b0);
    serve(1'b1, 8'h07, 1'b1);
    serve(1'b0, 8'h80, 1'b1);
    serve(1'b1, 8'hFF, 1'b0);

    // Tie after reset: client 0 first, held req1 granted 10 cycles later.
    do_reset();
    bus.req0 = 1'b1; bus.data0 = 8'h01;
    bus.req1 = 1'b1; bus.data1 = 8'h03;
    sb.push_back('{id: 1'b0, par: 1'b1 ^ ODD});
    sb.push_back('{id: 1'b1, par: 1'b0 ^ ODD});
    tick();
    chk("tie_gnt0", bus.gnt0, 1'b1);
    chk("tie_gnt1", bus.gnt1, 1'b0);
    bus.req0 = 1'b0;
    n = 0;
    while (!bus.gnt1 && n < 20) begin tick(); n++; end
    n_chk++;
    if (n != 10) begin
      n_fail++;
      $display("FAIL tie_spacing: got %0d cycles expected 10", n);
    end
    bus.req1 = 1'b0;
    n = 0;
    while (!bus.done && n < 20) begin tick(); n++; end
    chk("tie_second_done", bus.done, 1'b1);
    chk("tie_second_id", bus.done_id, 1'b1);
    tick();
    chk("tie_idle", bus.busy, 1'b0);

    // Abort on the 4th RUN edge.
    bus.req0 = 1'b1; bus.data0 = 8'hFE;
    tick();
    chk("abort_gnt0", bus.gnt0, 1'b1);
    bus.req0 = 1'b0;
    for (int k = 1; k <= 3; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_done", bus.done, 1'b0);
    chk("abort_parity", bus.parity, 1'b0);
    chk("abort_done_id", bus.done_id, 1'b0);
    for (int k = 0; k < 12; k++) tick();
    bus.req0 = 1'b1; bus.data0 = 8'h03;
    bus.req1 = 1'b1; bus.data1 = 8'h01;
    sb.push_back('{id: 1'b0, par: 1'b0 ^ ODD});
    tick();
    chk("abort_tie_gnt0", bus.gnt0, 1'b1);
    chk("abort_tie_gnt1", bus.gnt1, 1'b0);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    n = 0;
    while (!bus.done && n < 20) begin tick(); n++; end
    chk("abort_tie_done", bus.done, 1'b1);
    for (int k = 0; k < 4; k++) tick();

    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d pending results expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
